// File: rtl/alu_seq_multdiv.sv
// Iterative signed 32-bit multiply (radix-2 Booth) / divide (restoring) unit driving the shared ALU.
// Define ALU_SEQ_MULTDIV_DIV_EN to compile in the divide path; otherwise only MULT is serviced.
module alu_seq_multdiv (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy,
  output logic [31:0] alu_operandA,
  output logic [31:0] alu_operandB,
  output logic [4:0]  alu_opcode,
  output logic [4:0]  alu_shiftamt,
  input  logic [31:0] alu_result,
  input  logic        alu_overflow,
  input  logic        alu_isLessThan
);

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NEG_A,
    S_NEG_B,
    S_LOOP,
    S_FIX,
    S_DONE
  } state_t;

  state_t      state_q;
  logic [31:0] hi_q;      // Booth high word / division remainder
  logic [31:0] lo_q;      // Booth low word / division quotient
  logic        booth_q;
  logic [31:0] mcand_q;   // A for MULT, then magB for DIV
  logic [31:0] b_q;
  logic        op_div_q;
  logic [4:0]  cnt_q;
  logic [31:0] result_q;
  logic        exc_q;
  logic        rdy_q;
  logic        busy_q;

  logic        div_req;
  logic [31:0] rp;
  logic        uge;
  logic        sbit;
  logic [31:0] hi_d;
  logic [31:0] lo_d;
  logic        booth_d;
  logic [31:0] result_d;
  logic        exc_d;

`ifdef ALU_SEQ_MULTDIV_DIV_EN
  logic        sign_a_q;
  logic [31:0] quot;
  logic        div_exc;
  assign div_req = ctrl_DIV;
`else
  logic        unused_ctrl_div;
  assign unused_ctrl_div = ctrl_DIV;
  assign div_req         = 1'b0;
`endif

  assign rp   = {hi_q[30:0], lo_q[31]};
  // Unsigned R' >= magB recovered from the signed less-than flag
  assign uge  = ~(alu_isLessThan ^ rp[31] ^ mcand_q[31]);
  assign sbit = alu_result[31] ^ alu_overflow;

  always_comb begin
    alu_operandA = 32'd0;
    alu_operandB = 32'd0;
    alu_opcode   = OP_ADD;
    alu_shiftamt = 5'd0;
    case (state_q)
      S_NEG_A: begin
        alu_operandB = mcand_q;
        alu_opcode   = OP_SUB;
      end
      S_NEG_B: begin
        alu_operandB = b_q;
        alu_opcode   = OP_SUB;
      end
      S_LOOP: begin
        if (op_div_q) begin
          alu_operandA = rp;
          alu_operandB = mcand_q;
          alu_opcode   = OP_SUB;
        end else begin
          alu_operandA = hi_q;
          case ({lo_q[0], booth_q})
            2'b10: begin
              alu_operandB = mcand_q;
              alu_opcode   = OP_SUB;
            end
            2'b01: alu_operandB = mcand_q;
            default: alu_operandB = 32'd0;
          endcase
        end
      end
      S_FIX: begin
`ifdef ALU_SEQ_MULTDIV_DIV_EN
        alu_operandB = lo_q;
        alu_opcode   = OP_SUB;
`endif
      end
      default: ;
    endcase
  end

  always_comb begin
    if (op_div_q) begin
      hi_d    = uge ? alu_result : rp;
      lo_d    = {lo_q[30:0], uge};
      booth_d = booth_q;
    end else begin
      hi_d    = {sbit, alu_result[31:1]};
      lo_d    = {alu_result[0], lo_q[31:1]};
      booth_d = lo_q[0];
    end
  end

  always_comb begin
`ifdef ALU_SEQ_MULTDIV_DIV_EN
    quot    = (sign_a_q ^ b_q[31]) ? alu_result : lo_q;
    div_exc = (b_q == 32'd0) ||
              (!(sign_a_q ^ b_q[31]) && (lo_q == 32'h8000_0000));
    if (op_div_q) begin
      result_d = div_exc ? 32'd0 : quot;
      exc_d    = div_exc;
    end else begin
      result_d = lo_q;
      exc_d    = (hi_q != {32{lo_q[31]}});
    end
`else
    result_d = lo_q;
    exc_d    = (hi_q != {32{lo_q[31]}});
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      booth_q  <= 1'b0;
      mcand_q  <= 32'd0;
      b_q      <= 32'd0;
      op_div_q <= 1'b0;
      cnt_q    <= 5'd0;
      result_q <= 32'd0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
`ifdef ALU_SEQ_MULTDIV_DIV_EN
      sign_a_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          rdy_q <= 1'b0;
          if (ctrl_MULT || div_req) begin
            hi_q     <= 32'd0;
            lo_q     <= data_operandB;
            booth_q  <= 1'b0;
            mcand_q  <= data_operandA;
            b_q      <= data_operandB;
            op_div_q <= div_req && !ctrl_MULT;
            busy_q   <= 1'b1;
            state_q  <= S_NEG_A;
`ifdef ALU_SEQ_MULTDIV_DIV_EN
            sign_a_q <= data_operandA[31];
`endif
          end
        end
        S_NEG_A: begin
          if (op_div_q)
            lo_q <= mcand_q[31] ? alu_result : mcand_q;
          state_q <= S_NEG_B;
        end
        S_NEG_B: begin
          if (op_div_q)
            mcand_q <= b_q[31] ? alu_result : b_q;
          cnt_q   <= 5'd31;
          state_q <= S_LOOP;
        end
        S_LOOP: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          booth_q <= booth_d;
          if (cnt_q == 5'd0)
            state_q <= S_FIX;
          else
            cnt_q <= cnt_q - 5'd1;
        end
        S_FIX: begin
          result_q <= result_d;
          exc_q    <= exc_d;
          rdy_q    <= 1'b1;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          rdy_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_alu_seq_multdiv.sv
// Directed bench for alu_seq_multdiv with a behavioural model of the shared ALU.
module tb_alu_seq_multdiv;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_operandA, data_operandB;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;
  logic [31:0] alu_operandA, alu_operandB, alu_result;
  logic [4:0]  alu_opcode, alu_shiftamt;
  logic        alu_overflow, alu_isLessThan;

  int total = 0;
  int bad   = 0;
  logic [31:0] prev_res = 32'd0;
  logic        prev_exc = 1'b0;

  always #5 clock = ~clock;

  alu_seq_multdiv dut (
    .clock(clock), .reset(reset),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .busy(busy),
    .alu_operandA(alu_operandA), .alu_operandB(alu_operandB),
    .alu_opcode(alu_opcode), .alu_shiftamt(alu_shiftamt),
    .alu_result(alu_result), .alu_overflow(alu_overflow),
    .alu_isLessThan(alu_isLessThan)
  );

  always_comb begin
    if (alu_opcode == 5'd1) begin
      alu_result   = alu_operandA - alu_operandB;
      alu_overflow = (alu_operandA[31] != alu_operandB[31]) && (alu_result[31] != alu_operandA[31]);
    end else begin
      alu_result   = alu_operandA + alu_operandB;
      alu_overflow = (alu_operandA[31] == alu_operandB[31]) && (alu_result[31] != alu_operandA[31]);
    end
    alu_isLessThan = $signed(alu_operandA) < $signed(alu_operandB);
  end

  // Caller is at a negedge; the start pulse is sampled at the next posedge (edge 0).
  task automatic do_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input logic exp_exc, input string name);
    logic early;
    int   cyc;
    early = 1'b0;
    ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
    @(negedge clock);
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = 32'hDEAD_BEEF; data_operandB = 32'h1234_5678;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL %s busy_c1 got=%b exp=1", name, busy); end
    total++;
    if (data_result !== prev_res || data_exception !== prev_exc) begin
      bad++; $display("FAIL %s held_result got=%h/%b exp=%h/%b", name, data_result, data_exception, prev_res, prev_exc);
    end
    for (cyc = 1; cyc < 36; cyc++) begin
      if (data_resultRDY !== 1'b0) early = 1'b1;
      @(negedge clock);
    end
    total++;
    if (early) begin bad++; $display("FAIL %s early_rdy got=1 exp=0", name); end
    total++;
    if (data_resultRDY !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL %s rdy_c36 got rdy=%b busy=%b exp 1/1", name, data_resultRDY, busy);
    end
    total++;
    if (data_result !== exp_res) begin bad++; $display("FAIL %s result got=%h exp=%h", name, data_result, exp_res); end
    total++;
    if (data_exception !== exp_exc) begin bad++; $display("FAIL %s exception got=%b exp=%b", name, data_exception, exp_exc); end
    @(negedge clock);
    total++;
    if (data_resultRDY !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL %s c37 got rdy=%b busy=%b exp 0/0", name, data_resultRDY, busy);
    end
    prev_res = exp_res;
    prev_exc = exp_exc;
  endtask

  task automatic test_reset();
    reset = 1'b0; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = 32'd0; data_operandB = 32'd0;
    repeat (3) @(negedge clock);
    total++;
    if (data_result !== 32'd0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_outputs got=%h/%b/%b/%b exp all 0", data_result, data_exception, data_resultRDY, busy);
    end
    total++;
    if (alu_opcode !== 5'd0 || alu_operandA !== 32'd0 || alu_operandB !== 32'd0 || alu_shiftamt !== 5'd0) begin
      bad++; $display("FAIL reset_alu_drive got op=%h a=%h b=%h sh=%h exp 0", alu_opcode, alu_operandA, alu_operandB, alu_shiftamt);
    end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_mult();
    do_op(1, 0, 32'hFFFF_FFFD, 32'd7,       32'hFFFF_FFEB, 1'b0, "mult_m3x7");
    do_op(1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, "mult_ovf");
    do_op(1, 0, 32'h8000_0000, 32'd1,       32'h8000_0000, 1'b0, "mult_min_x1");
    do_op(1, 0, 32'd6,         32'hFFFF_FFFB, 32'hFFFF_FFE2, 1'b0, "mult_6xm5");
    do_op(1, 0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, "mult_minxmin");
  endtask

  task automatic test_both_pulses();
    do_op(1, 1, 32'd6, 32'd3, 32'd18, 1'b0, "mult_div_same_cycle");
  endtask

`ifdef ALU_SEQ_MULTDIV_DIV_EN
  task automatic test_div();
    do_op(0, 1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, "div_m7_2");
    do_op(0, 1, 32'd100,       32'd0,         32'd0,         1'b1, "div_by_zero");
    do_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1, "div_min_m1");
    do_op(0, 1, 32'h8000_0000, 32'h8000_0000, 32'd1,         1'b0, "div_min_min");
    do_op(0, 1, 32'd100,       32'd7,         32'd14,        1'b0, "div_100_7");
    do_op(0, 1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        1'b0, "div_m100_m7");
  endtask
`else
  task automatic test_no_div();
    logic seen_busy, seen_rdy;
    seen_busy = 1'b0; seen_rdy = 1'b0;
    ctrl_DIV = 1'b1; data_operandA = 32'd100; data_operandB = 32'd5;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy !== 1'b0) seen_busy = 1'b1;
      if (data_resultRDY !== 1'b0) seen_rdy = 1'b1;
      @(negedge clock);
    end
    total++;
    if (seen_busy) begin bad++; $display("FAIL no_div_busy got=1 exp=0"); end
    total++;
    if (seen_rdy) begin bad++; $display("FAIL no_div_rdy got=1 exp=0"); end
  endtask
`endif

  task automatic test_ignore_div();
    logic early;
    early = 1'b0;
    ctrl_MULT = 1'b1; data_operandA = 32'd5; data_operandB = 32'd9;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    for (int cyc = 1; cyc < 36; cyc++) begin
      ctrl_DIV = (cyc == 10);
      if (cyc == 10) begin data_operandA = 32'd77; data_operandB = 32'd7; end
      if (data_resultRDY !== 1'b0) early = 1'b1;
      @(negedge clock);
    end
    ctrl_DIV = 1'b0;
    total++;
    if (early) begin bad++; $display("FAIL ignore_div early_rdy got=1 exp=0"); end
    total++;
    if (data_resultRDY !== 1'b1 || data_result !== 32'd45 || data_exception !== 1'b0) begin
      bad++; $display("FAIL ignore_div got rdy=%b res=%h exc=%b exp 1/0000002d/0", data_resultRDY, data_result, data_exception);
    end
    @(negedge clock);
    prev_res = 32'd45; prev_exc = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic seen;
    seen = 1'b0;
    ctrl_MULT = 1'b1; data_operandA = 32'd3; data_operandB = 32'd4;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    for (int cyc = 1; cyc < 20; cyc++) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    total++;
    if (busy !== 1'b0 || data_result !== 32'd0 || data_resultRDY !== 1'b0) begin
      bad++; $display("FAIL reset_mid got busy=%b res=%h rdy=%b exp 0/0/0", busy, data_result, data_resultRDY);
    end
    for (int i = 0; i < 30; i++) begin
      if (data_resultRDY !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      @(negedge clock);
    end
    total++;
    if (seen) begin bad++; $display("FAIL reset_mid_after got activity exp none"); end
    prev_res = 32'd0; prev_exc = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_op(1, 0, 32'd1000, 32'd1000, 32'd1000000, 1'b0, "b2b_first");
    do_op(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, "b2b_second");
  endtask

  initial begin
    test_reset();
    test_mult();
    test_both_pulses();
`ifdef ALU_SEQ_MULTDIV_DIV_EN
    test_div();
`else
    test_no_div();
`endif
    test_ignore_div();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq_multdiv.md
# alu_seq_multdiv

Iterative signed 32-bit multiply/divide unit that issues its arithmetic through the processor's shared ALU. It drives the ALU operand, opcode and shift-amount inputs and consumes the ALU result and flags. It sits beside the execute stage, and the pipeline stalls while `busy` is high. Both operations complete in a fixed 36 cycles.

## Interface
- No parameters. Operand width is fixed at 32.
- `clock` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-low reset.
- `ctrl_MULT` in 1: one-cycle start pulse; data_operandA × data_operandB.
- `ctrl_DIV` in 1: one-cycle start pulse; data_operandA ÷ data_operandB.
- `data_operandA`, `data_operandB` in 32: two's-complement operands, sampled on the start cycle.
- `data_result` out 32: low product word or truncated quotient.
- `data_exception` out 1: result invalid (overflow or divide by zero).
- `data_resultRDY` out 1: one-cycle completion strobe.
- `busy` out 1: operation in progress.
- `alu_operandA`, `alu_operandB` out 32: ALU operand drive.
- `alu_opcode` out 5: 00000 ADD, 00001 SUB; no other codes are issued.
- `alu_shiftamt` out 5: constant 0.
- `alu_result` in 32: combinational ALU result, same cycle.
- `alu_overflow`, `alu_isLessThan` in 1: ALU signed-overflow and signed A<B flags.

## Operation
- States: IDLE, NEG_A, NEG_B, LOOP (32 iterations, 5-bit counter), FIX, DONE.
- IDLE:
  - `ctrl_MULT` or `ctrl_DIV` latches A, B and the op, then moves to NEG_A.
  - If both pulses are high, MULT wins.
  - Pulses are ignored in every other state.
  - ALU drive is ADD 0+0.
- NEG_A issues SUB 0−A; magA = A[31] ? alu_result : A. NEG_B does the same for B → magB. Both states run for MULT too; their results are unused.
- MULT, radix-2 Booth:
  - Initial state: hi=0, lo=B, q=0, mcand=A.
  - Per LOOP cycle, pair {lo[0],q}: 10 → SUB hi−mcand; 01 → ADD hi+mcand; 00/11 → ADD hi+0.
  - With s = alu_result[31] ^ alu_overflow: hi ← {s, alu_result[31:1]}, lo ← {alu_result[0], lo[31:1]}, q ← lo[0].
  - Result = lo. Exception if hi ≠ {32{lo[31]}}.
- DIV, restoring on magnitudes:
  - Initial state: R=0, Q=magA.
  - Per LOOP cycle: R' = {R[30:0], Q[31]}; issue SUB R'−magB.
  - uge = ~(alu_isLessThan ^ R'[31] ^ magB[31]).
  - If uge: R ← alu_result and Q ← {Q[30:0],1}; else R ← R' and Q ← {Q[30:0],0}.
- FIX issues SUB 0−Q.
  - Quotient = (A[31]^B[31]) ? alu_result : Q.
  - Exception if B==0, or if the signs match and Q==0x80000000.
  - On exception, data_result = 0. Remainder is not output.
- DONE pulses `data_resultRDY`, then returns to IDLE.

## Timing
- Start pulse sampled at edge 0.
- NEG_A occupies cycle 1, NEG_B cycle 2, LOOP cycles 3–34, FIX cycle 35.
- `data_resultRDY` is high during cycle 36 only.
- The next start pulse is accepted in cycle 37.
- `data_result` and `data_exception` update at the edge entering DONE and hold until the next completion.
- `busy` is high from cycle 1 through cycle 36.
- Reset values: data_result=0, data_exception=0, data_resultRDY=0, busy=0; ALU drive is ADD 0+0; state IDLE.
- Reset mid-operation aborts to IDLE with no `data_resultRDY`, and the held result is cleared to 0.
- Latency is fixed at 36 cycles regardless of operand values, including divide by zero.

## Configuration
- `ALU_SEQ_MULTDIV_DIV_EN` defined: divide path, FIX negation and divide exceptions are compiled in.
- Undefined:
  - `ctrl_DIV` is treated as 0.
  - FIX issues ADD 0+0 and the result is taken from lo.
  - Only MULT produces `data_resultRDY`.

## Test plan
- MULT −3 × 7 → cycle 36: RDY=1, result 0xFFFFFFEB, exception 0.
- MULT 0x00010000 × 0x00010000 → result 0x00000000, exception 1. MULT 0x80000000 × 1 → result 0x80000000, exception 0.
- DIV −7 ÷ 2 → result 0xFFFFFFFD, exception 0. DIV 100 ÷ 0 → result 0, exception 1.
- DIV 0x80000000 ÷ 0xFFFFFFFF → exception 1. DIV 0x80000000 ÷ 0x80000000 → result 1.
- Reset low at cycle 20 of a MULT → next cycle busy=0, result 0; RDY never pulses. A `ctrl_DIV` pulse at cycle 10 of a MULT is ignored.
- Same-cycle MULT+DIV on 6 and 3 → result 18. Rebuild without the macro: a DIV pulse gives no busy and no RDY.
